// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU control slice: sequencer state
// encoding, array geometry and the per-lane element index type.
package tpu_pkg;

  localparam int ARRAY_DIM   = 4;
  localparam int ELEM_W      = 2;
  localparam int FEED_LEN    = 2 * ARRAY_DIM - 1;
  localparam int NUM_RESULTS = ARRAY_DIM * ARRAY_DIM;
  localparam int RES_W       = $clog2(NUM_RESULTS);
  localparam int T_W         = 4;

  typedef logic [ELEM_W-1:0] elem_idx_t;
  typedef logic [T_W-1:0]    t_cnt_t;
  typedef logic [RES_W-1:0]  res_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_READOUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/skew_gen.sv
// Skewed read pattern for one memory: lane r is enabled for DIM cycles
// starting at t=r and reads element t-r. Purely combinational.
module skew_gen
  import tpu_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int IDX_W = 2
) (
  input  t_cnt_t                 t,
  input  logic                   active,
  output logic [DIM-1:0]         enable,
  output logic [DIM*IDX_W-1:0]   elem
);

  // Per-lane window test and index; disabled lanes present index 0.
  always_comb begin
    enable = '0;
    elem   = '0;
    for (int r = 0; r < DIM; r++) begin
      int diff;
      diff = int'(t) - r;
      if (active && diff >= 0 && diff <= DIM - 1) begin
        enable[r]                 = 1'b1;
        elem[r*IDX_W +: IDX_W]    = diff[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for one 4x4 systolic matrix multiply: skewed operand feed,
// drain, then a valid/ready walk over the 16 results.
// Optional build macro MATMUL_SEQ_PERF_EN adds a 16-bit busy-cycle counter
// on port perf_cycles.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for start, all outputs low
// ST_FEED    | 7 cycles of skewed reads from A and B, array_we high
// ST_DRAIN   | DRAIN_LEN cycles letting partial sums settle, array_we high
// ST_READOUT | present results row-major under valid/ready
// ST_DONE    | one-cycle done pulse, then back to idle
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int DIM       = 4,
  parameter int IDX_W     = 2,
  parameter int DRAIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [DIM-1:0]       mema_read_enable,
  output logic [DIM*IDX_W-1:0] mema_read_elem,
  output logic [DIM-1:0]       memb_read_enable,
  output logic [DIM*IDX_W-1:0] memb_read_elem,
  output logic                 array_we,
  output logic [1:0]           result_row,
  output logic [1:0]           result_col,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 done
`ifdef MATMUL_SEQ_PERF_EN
  ,output logic [15:0]         perf_cycles
`endif
);

  state_t   state_q, state_d;
  t_cnt_t   t_q, t_d;
  res_idx_t idx_q, idx_d;
  logic     feed_active;

  // State, cycle counter and result index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; abort wins over every transition.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = ST_IDLE;
      t_d     = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FEED;
            t_d     = '0;
          end
        end
        ST_FEED: begin
          if (t_q == t_cnt_t'(FEED_LEN - 1)) begin
            state_d = ST_DRAIN;
            t_d     = '0;
          end else begin
            t_d = t_q + t_cnt_t'(1);
          end
        end
        ST_DRAIN: begin
          if (t_q == t_cnt_t'(DRAIN_LEN - 1)) begin
            state_d = ST_READOUT;
            t_d     = '0;
          end else begin
            t_d = t_q + t_cnt_t'(1);
          end
        end
        ST_READOUT: begin
          if (result_ready) begin
            if (idx_q == res_idx_t'(NUM_RESULTS - 1)) begin
              state_d = ST_DONE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + res_idx_t'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          t_d     = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from state only; the index register is zero
  // outside READOUT so row/col need no extra gating.
  always_comb begin
    feed_active  = (state_q == ST_FEED);
    array_we     = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    result_valid = (state_q == ST_READOUT);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    result_row   = idx_q[3:2];
    result_col   = idx_q[1:0];
  end

  // A and B share the same skew; two instances keep the ports independent.
  skew_gen #(.DIM(DIM), .IDX_W(IDX_W)) u_skew_a (
    .t      (t_q),
    .active (feed_active),
    .enable (mema_read_enable),
    .elem   (mema_read_elem)
  );

  skew_gen #(.DIM(DIM), .IDX_W(IDX_W)) u_skew_b (
    .t      (t_q),
    .active (feed_active),
    .enable (memb_read_enable),
    .elem   (memb_read_elem)
  );

`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] perf_q;

  // Busy-cycle counter: cleared on an accepted start, saturating, held in idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == ST_IDLE && start && !abort) begin
      perf_q <= '0;
    end else if (state_q != ST_IDLE && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed feed/drain timing,
// randomized readout backpressure and operands, scoreboard on handshakes.
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, result_ready;
  logic [3:0] mema_read_enable, memb_read_enable;
  logic [7:0] mema_read_elem, memb_read_elem;
  logic       array_we, result_valid, busy, done;
  logic [1:0] result_row, result_col;
`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  matmul_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .mema_read_enable (mema_read_enable),
    .mema_read_elem   (mema_read_elem),
    .memb_read_enable (memb_read_enable),
    .memb_read_elem   (memb_read_elem),
    .array_we         (array_we),
    .result_row       (result_row),
    .result_col       (result_col),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .busy             (busy),
    .done             (done)
`ifdef MATMUL_SEQ_PERF_EN
    ,.perf_cycles     (perf_cycles)
`endif
  );

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  int   jobs = 0;
  int   amat[4][4];
  int   bmat[4][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int cval(input int i, input int j);
    int s = 0;
    for (int k = 0; k < 4; k++) s += amat[i][k] * bmat[k][j];
    return s;
  endfunction

  function automatic logic [3:0] exp_en(input int t);
    logic [3:0] e = '0;
    for (int r = 0; r < 4; r++) if (t >= r && t <= r + 3) e[r] = 1'b1;
    return e;
  endfunction

  function automatic logic [7:0] exp_elem(input int t);
    logic [7:0] e = '0;
    int d;
    for (int r = 0; r < 4; r++) begin
      d = t - r;
      if (d >= 0 && d <= 3) e[2*r +: 2] = d[1:0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts done pulses, checks index hold under stall, scoreboards handshakes.
  bit         prev_stall = 0;
  logic [3:0] prev_idx = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (done) done_count++;
      if (result_valid) begin
        if (prev_stall) chk("idx_hold", {28'd0, result_row, result_col}, {28'd0, prev_idx});
        if (result_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_idx", {28'd0, result_row, result_col}, e.idx);
            chk("result_val", cval(int'(result_row), int'(result_col)), e.val);
          end
        end
        prev_stall = !result_ready;
        prev_idx   = {result_row, result_col};
      end else begin
        prev_stall = 0;
      end
    end
  end

  // mode 0: always ready, 1: 1,0,0 repeating, 2: random, 3: three-cycle stall first
  function automatic logic ready_pat(input int mode, input int step);
    case (mode)
      0: return 1'b1;
      1: return (step % 3 == 0);
      2: return 1'($urandom_range(0, 1));
      default: return (step >= 3);
    endcase
  endfunction

  task automatic run_job(input int mode, input bit inject);
    int  cyc, stalls, step;
    bit  seen;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        amat[i][j] = (i == j) ? 1 : 0;
        bmat[i][j] = int'($urandom_range(0, 255));
      end
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back('{i, bmat[i/4][i%4]});
    jobs++;
    cyc = 1;
    for (int t = 0; t < 7; t++) begin
      start = (inject && t == 2);
      @(negedge clk);
      chk("feed_en_a", {28'd0, mema_read_enable}, {28'd0, exp_en(t)});
      chk("feed_en_b", {28'd0, memb_read_enable}, {28'd0, exp_en(t)});
      chk("feed_elem_a", {24'd0, mema_read_elem}, {24'd0, exp_elem(t)});
      chk("feed_elem_b", {24'd0, memb_read_elem}, {24'd0, exp_elem(t)});
      if (t == 3) chk("elem_t3", {24'd0, mema_read_elem}, 32'h1B);
      chk("feed_ctl", {28'd0, array_we, busy, result_valid, done}, 32'b1100);
      tick();
      cyc++;
    end
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("drain_ctl", {22'd0, mema_read_enable, memb_read_enable, array_we, busy, result_valid, done},
          32'b1100);
      tick();
      cyc++;
    end
    seen = 0;
    stalls = 0;
    step = 0;
    while (!seen && cyc < 300) begin
      result_ready = ready_pat(mode, step);
      start = inject;
      @(negedge clk);
      if (step == 0) chk("readout_first", {30'd0, result_valid, array_we}, 32'b10);
      if (done) begin
        seen = 1;
        chk("done_cycle", cyc, 28 + stalls);
        chk("all_results_seen", exp_q.size(), 0);
      end else if (result_valid && !result_ready) begin
        stalls++;
      end
      tick();
      cyc++;
      step++;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("after_done_idle", {30'd0, busy, done}, 0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("perf_cycles", {16'd0, perf_cycles}, 28 + stalls);
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", {mema_read_enable, mema_read_elem, memb_read_enable, memb_read_elem,
                         array_we, result_row, result_col, result_valid, busy, done}, 0);
    end
`ifdef MATMUL_SEQ_PERF_EN
    chk("perf_reset", {16'd0, perf_cycles}, 0);
`endif
    tick();

    run_job(0, 0);
    run_job(1, 0);
    run_job(3, 0);

    // Abort in FEED at t=3.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_pre_en", {28'd0, mema_read_enable}, 32'hF);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {22'd0, mema_read_enable, memb_read_enable, array_we, busy, result_valid, done}, 0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("perf_abort", {16'd0, perf_cycles}, 4);
`endif
    repeat (35) tick();

    run_job(0, 0);
    run_job(2, 1);
    run_job(2, 0);

    // start together with abort in IDLE must not launch.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", {31'd0, busy}, 0);
    tick();

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {30'd0, busy, array_we}, 0);
    tick();
    rst = 1'b0;
    repeat (35) tick();

    chk("done_count", done_count, jobs);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Hardware sequencer that runs one complete 4x4 matrix multiply on the systolic array and then streams the 16 results out. After a single `start` pulse it drives skewed per-lane read enables and element indices into memory A and memory B, holds the array write enable through feed and drain, and then walks the result row/column select under a valid/ready handshake. It sits between the instruction control unit, which issues `start`, and the memory/array datapath. It replaces hand-issued per-cycle read instructions.

## Interface
- `DIM`, 4: array dimension and lanes per memory. Only 4 is supported, because the element index is 2 bits per lane.
- `IDX_W`, 2: element index width per lane.
- `DRAIN_LEN`, 4: number of cycles `array_we` stays high after the last operand is read.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: single-cycle request to begin a multiply. Sampled only in IDLE.
- `abort` input 1: synchronous abort. It has priority over everything except `rst`.
- `mema_read_enable` output DIM: per-lane read enable for memory A.
- `mema_read_elem` output DIM*IDX_W: per-lane element index for memory A. Lane r uses bits [2r+1:2r].
- `memb_read_enable` output DIM: per-lane read enable for memory B.
- `memb_read_elem` output DIM*IDX_W: per-lane element index for memory B.
- `array_we` output 1: array accumulate enable.
- `result_row` output 2: result row select for the result mux.
- `result_col` output 2: result column select for the result mux.
- `result_valid` output 1: the selected result is valid.
- `result_ready` input 1: the consumer accepts the current result.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- States are IDLE, FEED, DRAIN, READOUT and DONE. A counter `t` counts cycles within a state.
- **IDLE:** all outputs are 0. If `start` is 1, go to FEED with t=0.
- **FEED:** lasts 2*DIM-1 = 7 cycles, t=0..6.
  - Lane r is enabled when r ≤ t ≤ r+DIM-1.
  - Lane r element index = t-r. The index is 0 when the lane is disabled.
  - Memory A and memory B use identical patterns.
  - `array_we`=1.
  - At t=6, go to DRAIN with t=0.
- **DRAIN:** lasts `DRAIN_LEN` cycles. Read enables are 0 and `array_we`=1. On the last cycle, go to READOUT.
- **READOUT:**
  - `array_we`=0 and `result_valid`=1.
  - The index {row,col} starts at 0 and increments on each cycle where valid && ready. Column is least significant.
  - If ready is low, the index holds.
  - A handshake at index 15 goes to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE. `start` in DONE is ignored.
- **`start` outside IDLE:** ignored, never queued.
- **`abort`:** in any state, next cycle is IDLE with every output 0 and no `done` pulse. `abort` and `start` together in IDLE stays in IDLE.
- **`rst` asserted mid-operation:** immediate IDLE. This is an asynchronous clear.

## Timing
- Reset values: all outputs 0. `result_row`, `result_col` and `t` are 0.
- All outputs are registered, or decoded only from state and `t`. There is no combinational path from input to output except `result_ready`, which only affects the next-state decision.
- Cycle numbering: `start` high at edge k.
  - FEED occupies cycles k+1..k+7.
  - DRAIN occupies cycles k+8..k+11.
  - READOUT begins at cycle k+12.
  - With `result_ready` held at 1, DONE is cycle k+28 and IDLE is cycle k+29.
- `busy` rises in cycle k+1 and falls in the cycle after DONE.
- Minimum start-to-start interval is 29 cycles.
- Result data is read combinationally by the top-level mux in the same cycle as `result_row`/`result_col`.

## Configuration
- **`MATMUL_SEQ_PERF_EN`**
  - **Defined:** adds output `perf_cycles`, 16 bits.
    - Cleared when `start` is accepted.
    - Increments every cycle while `busy`=1, including READOUT stall cycles.
    - Saturates at 16'hFFFF.
    - Holds its value in IDLE.
    - Resets to 0.
  - **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- The shared package `tpu_pkg` holds:
  - the state enum;
  - the localparams `FEED_LEN` = 2*DIM-1 and `NUM_RESULTS` = DIM*DIM;
  - the lane/element index type.
- One sub-module, `skew_gen`: combinational, mapping (`t`, active) to the enable and index vectors. It is instantiated twice, for A and B, so the skew logic is shared and unit-testable.

## Test plan
- **Reset then idle:** assert `rst` for 2 cycles and hold `start`=0 → all outputs 0 and `busy`=0 for 10 cycles.
- **Single run with `result_ready`=1:** `start` at k →
  - `mema_read_enable` sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000;
  - at t=3, `mema_read_elem`=8'b00_01_10_11;
  - `array_we` high k+1..k+11;
  - 16 results in order 0..15;
  - `done` at k+28;
  - with A=identity, each result equals the corresponding B element.
- **Backpressure:** `result_ready` toggles 1,0,0,1,… → the index holds while ready is 0; all 16 indices appear exactly once; `done` follows the last handshake.
- **Abort mid-FEED** at t=3 → IDLE next cycle, enables 0, no `done`; a following `start` runs normally.
- **`start` during `busy`** and during DONE → ignored; exactly one `done` per accepted `start`.
- **With `MATMUL_SEQ_PERF_EN`:** the run from the second scenario → `perf_cycles` = 28. A 3-cycle ready stall → 31.
